// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, default memory depth.
package load_store_unit_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } lsu_state_e;

  // Anything not legal for the access direction is handled as a word access.
  function automatic logic [2:0] norm_funct3(input logic is_load, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return f3;
      F3_BU, F3_HU:     return is_load ? f3 : F3_W;
      default:          return F3_W;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [31:0] merge_word,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    store_data = merge_word;
    case (funct3)
      F3_B: begin
        case (lane)
          2'd0:    store_data[7:0]   = wdata[7:0];
          2'd1:    store_data[15:8]  = wdata[7:0];
          2'd2:    store_data[23:16] = wdata[7:0];
          default: store_data[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) store_data[31:16] = wdata[15:0];
        else         store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage front end: sub-word loads/stores over a word-organised memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign
);

  lsu_state_e       state_q, state_d;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      merge_q;
  logic [31:0]      rdata_q;
  logic [31:0]      load_data;
  logic [31:0]      store_data;

  logic [2:0]       f3_in;
  logic             is_half_in;
  logic             is_word_in;
  logic [1:0]       lane_in;
  logic             trap_in;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:IDX_W+2];

  assign f3_in      = norm_funct3(req_load, req_funct3);
  assign is_half_in = (f3_in == F3_H) || (f3_in == F3_HU);
  assign is_word_in = (f3_in == F3_W);

  // Aligning unconditionally is harmless: with trapping on, misaligned requests never touch memory.
  always_comb begin
    lane_in = req_addr[1:0];
    if (is_half_in) lane_in[0] = 1'b0;
    if (is_word_in) lane_in    = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap_in       = (is_half_in && req_addr[0]) || (is_word_in && (req_addr[1:0] != 2'b00));
  assign resp_misalign = misalign_q;
`else
  assign trap_in       = 1'b0;
  assign resp_misalign = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .funct3     (f3_q),
    .lane       (lane_q),
    .rd_word    (mem_rd),
    .wdata      (wdata_q),
    .merge_word (merge_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (trap_in)            state_d = S_RESP;
          else if (req_load)      state_d = S_LOAD;
          else if (is_word_in)    state_d = S_WRITE;
          else                    state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        mem_addr = {{(32-IDX_W){1'b0}}, idx_q};
        state_d  = S_RESP;
      end
      S_RMW_RD: begin
        mem_addr = {{(32-IDX_W){1'b0}}, idx_q};
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        mem_addr = {{(32-IDX_W){1'b0}}, idx_q};
        mem_wd   = store_data;
        mem_we   = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      f3_q       <= '0;
      lane_q     <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_q    <= f3_in;
            lane_q  <= lane_in;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
            if (trap_in) begin
              rdata_q    <= '0;
              misalign_q <= 1'b1;
            end
`endif
          end
        end
        S_LOAD: begin
          rdata_q    <= load_data;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
        end
        S_RMW_RD: merge_q <= mem_rd;
        S_WRITE: begin
          rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wd;

  load_store_unit #(.MEM_WORDS(1024), .IDX_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_load      (req_load),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .mem_addr      (mem_addr),
    .mem_wd        (mem_wd),
    .mem_we        (mem_we),
    .mem_rd        (mem_rd),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign)
  );

  // Issues one request once the unit is idle and follows it to its response.
  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                       output logic mis, output int pulses, output logic [31:0] wa,
                       output logic [31:0] wdo, output logic [31:0] first_addr);
    int w;
    lat = 0; rdata = 'x; mis = 1'bx; pulses = 0; wa = 'x; wdo = 'x; first_addr = 'x;
    w = 0;
    while (!req_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
    end
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    first_addr = mem_addr;
    for (int c = 1; c <= 8; c++) begin
      if (mem_we) begin pulses++; wa = mem_addr; wdo = mem_wd; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; mis = resp_misalign; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", mem_we); end
    checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL rst_wd: got %h want 0", mem_wd); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %0b want 0", resp_misalign); end
  endtask

  task automatic test_load_subword();
    int lat, p; logic [31:0] rd, wa, wd, fa; logic mis;
    issue(1'b1, 3'b000, 32'h15, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_data: got %h want ffffffaa", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lb_latency: got %0d want 2", lat); end
    checks++; if (fa !== 32'd5) begin errors++; $display("FAIL lb_mem_addr: got %h want 5", fa); end
    issue(1'b1, 3'b100, 32'h15, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu_data: got %h want 000000aa", rd); end
    issue(1'b1, 3'b001, 32'h16, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'hFFFF8899) begin errors++; $display("FAIL lh_hi_data: got %h want ffff8899", rd); end
    issue(1'b1, 3'b101, 32'h14, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'h0000AABB) begin errors++; $display("FAIL lhu_lo_data: got %h want 0000aabb", rd); end
    checks++; if (p !== 0) begin errors++; $display("FAIL load_no_write: got %0d pulses want 0", p); end
  endtask

  task automatic test_store_subword();
    int lat, p; logic [31:0] rd, wa, wd, fa; logic mis;
    issue(1'b0, 3'b000, 32'h16, 32'h000000CC, lat, rd, mis, p, wa, wd, fa);
    checks++; if (p !== 1) begin errors++; $display("FAIL sb_pulses: got %0d want 1", p); end
    checks++; if (wa !== 32'd5) begin errors++; $display("FAIL sb_addr: got %h want 5", wa); end
    checks++; if (wd !== 32'h88CCAABB) begin errors++; $display("FAIL sb_wd: got %h want 88ccaabb", wd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h want 0", rd); end
    issue(1'b0, 3'b001, 32'h14, 32'hFFFF1234, lat, rd, mis, p, wa, wd, fa);
    checks++; if (wd !== 32'h88CC1234) begin errors++; $display("FAIL sh_wd: got %h want 88cc1234", wd); end
    checks++; if (mem[5] !== 32'h88CC1234) begin errors++; $display("FAIL sh_mem: got %h want 88cc1234", mem[5]); end
  endtask

  task automatic test_store_word_load();
    int lat, p; logic [31:0] rd, wa, wd, fa; logic mis;
    issue(1'b0, 3'b010, 32'h40, 32'hDEADBEEF, lat, rd, mis, p, wa, wd, fa);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (wa !== 32'h10 || p !== 1) begin errors++; $display("FAIL sw_write: got addr %h pulses %0d want 10/1", wa, p); end
    issue(1'b1, 3'b010, 32'h40, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    issue(1'b1, 3'b001, 32'h42, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_data: got %h want ffffdead", rd); end
    issue(1'b1, 3'b101, 32'h40, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_data: got %h want 0000beef", rd); end
    issue(1'b1, 3'b000, 32'h43, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb3_data: got %h want ffffffde", rd); end
  endtask

  task automatic test_misalign();
    int lat, p; logic [31:0] rd, wa, wd, fa; logic mis;
    issue(1'b1, 3'b010, 32'h41, 32'h0, lat, rd, mis, p, wa, wd, fa);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_lw_latency: got %0d want 1", lat); end
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL mis_lw_flag: got %0b want 1", mis); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_lw_rdata: got %h want 0", rd); end
    issue(1'b0, 3'b001, 32'h43, 32'h00007777, lat, rd, mis, p, wa, wd, fa);
    checks++; if (p !== 0 || mis !== 1'b1) begin errors++; $display("FAIL mis_sh_trap: got pulses %0d flag %0b want 0/1", p, mis); end
    checks++; if (mem[16] !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_sh_mem: got %h want deadbeef", mem[16]); end
`else
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_lw_latency: got %0d want 2", lat); end
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL mis_lw_flag: got %0b want 0", mis); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_lw_rdata: got %h want deadbeef", rd); end
    issue(1'b1, 3'b001, 32'h43, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL mis_lh_rdata: got %h want ffffdead", rd); end
`endif
  endtask

  task automatic test_illegal_funct3();
    int lat, p; logic [31:0] rd, wa, wd, fa; logic mis;
    issue(1'b1, 3'b011, 32'h40, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ill_load: got %h want deadbeef", rd); end
    issue(1'b0, 3'b100, 32'h20, 32'hCAFEF00D, lat, rd, mis, p, wa, wd, fa);
    checks++; if (lat !== 2 || wd !== 32'hCAFEF00D) begin errors++; $display("FAIL ill_store: got lat %0d wd %h want 2/cafef00d", lat, wd); end
    checks++; if (mem[8] !== 32'hCAFEF00D) begin errors++; $display("FAIL ill_store_mem: got %h want cafef00d", mem[8]); end
  endtask

  task automatic test_wrap();
    int lat, p; logic [31:0] rd, wa, wd, fa; logic mis;
    issue(1'b1, 3'b010, 32'h1004, 32'h0, lat, rd, mis, p, wa, wd, fa);
    checks++; if (fa !== 32'd1) begin errors++; $display("FAIL wrap_addr: got %h want 1", fa); end
    checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL wrap_data: got %h want 01234567", rd); end
  endtask

  task automatic test_reset_mid_write();
    int w;
    mem[48] = 32'h55667788;
    w = 0;
    while (!req_ready && w < 10) begin @(posedge clk); #1; w++; end
    req_valid = 1'b1; req_load = 1'b0; req_funct3 = 3'b001; req_addr = 32'hC2; req_wdata = 32'h0000ABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rmw_we_before_rst: got %0b want 1", mem_we); end
    rst = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we_drop: got %0b want 0", mem_we); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (mem[48] !== 32'h55667788) begin errors++; $display("FAIL rst_mem_kept: got %h want 55667788", mem[48]); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0b want 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int accepts, resps, bad, w;
    accepts = 0; resps = 0; bad = 0; w = 0;
    while (!req_ready && w < 10) begin @(posedge clk); #1; w++; end
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (req_ready) accepts++;
      if (resp_valid) begin
        resps++;
        if (resp_rdata !== 32'hDEADBEEF) bad++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++; if (accepts !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", accepts); end
    checks++; if (resps !== 3 || bad !== 0) begin errors++; $display("FAIL b2b_resps: got %0d (bad %0d) want 3 (0)", resps, bad); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 32'h8899AABB;
    mem[1] = 32'h01234567;
    rst = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    test_load_subword();
    test_store_subword();
    test_store_word_load();
    test_misalign();
    test_illegal_funct3();
    test_wrap();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
